wb_arbiter: RTL

Two-master to one-slave pipelined WISHBONE arbiter sharing the instruction/data memory port between the FETCH stage (master F) and the MEMORY stage (master M). Grants the bus to one master for the full duration of its cycle (cyc high), routes ack/data/stall back, and holds the other master stalled. A per-grant watchdog aborts a cycle that receives no ack in time and signals an error to the owning master.

---
 rtl/wb_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Two-master to one-slave pipelined WISHBONE arbiter (FETCH=F, MEMORY=M)
// with whole-cycle grants and a per-grant no-ack watchdog.
module wb_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int PRIO_M  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          f_cyc_i,
  input  logic          f_stb_i,
  output logic          f_stall_o,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_ack_o,
  output logic          f_err_o,
  output logic [DW-1:0] f_data_o,
  input  logic          m_cyc_i,
  input  logic          m_stb_i,
  input  logic          m_we_i,
  output logic          m_stall_o,
  input  logic [AW-1:0] m_addr_i,
  input  logic [DW-1:0] m_data_i,
  output logic          m_ack_o,
  output logic          m_err_o,
  output logic [DW-1:0] m_data_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  input  logic          wb_stall_i,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_data_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_data_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_F,
    GNT_M,
    ABORT
  } state_t;

  state_t        state;
  state_t        state_d;
  logic          last_m;
  logic          last_m_d;
  logic          own_m;
  logic          own_m_d;
  logic [CW-1:0] wdog;
  logic [CW-1:0] wdog_d;
  logic          expire;
  logic          m_wins;

  // Cycle TIMEOUT without an ack is the last one the grant may hold the bus.
  assign expire = !wb_ack_i && (wdog == WD_LAST);

  // M takes an idle-bus request on priority, when alone, or when F went last.
  assign m_wins = m_cyc_i && ((PRIO_M != 0) || !f_cyc_i || !last_m);

  // State, round-robin pointer, abort owner and watchdog registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      last_m <= 1'b0;
      own_m  <= 1'b0;
      wdog   <= '0;
    end else begin
      state  <= state_d;
      last_m <= last_m_d;
      own_m  <= own_m_d;
      wdog   <= wdog_d;
    end
  end

  // Next-state: grants hold until the owner drops cyc or the watchdog fires.
  always_comb begin
    state_d  = state;
    last_m_d = last_m;
    own_m_d  = own_m;
    unique case (state)
      IDLE: begin
        if (m_wins) begin
          state_d = GNT_M;
        end else if (f_cyc_i) begin
          state_d = GNT_F;
        end
      end
      GNT_F: begin
        if (!f_cyc_i) begin
          last_m_d = 1'b0;
          state_d  = m_cyc_i ? GNT_M : IDLE;
        end else if (expire) begin
          last_m_d = 1'b0;
          own_m_d  = 1'b0;
          state_d  = ABORT;
        end
      end
      GNT_M: begin
        if (!m_cyc_i) begin
          last_m_d = 1'b1;
          state_d  = f_cyc_i ? GNT_F : IDLE;
        end else if (expire) begin
          last_m_d = 1'b1;
          own_m_d  = 1'b1;
          state_d  = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Watchdog counts ackless bus cycles; any ack or state change clears it.
  always_comb begin
    wdog_d = '0;
    if ((state_d == state) && wb_cyc_o && !wb_ack_i) begin
      wdog_d = wdog + 1'b1;
    end
  end

  // Bus routing: only the granted master sees the slave; the other stalls.
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_addr_o = '0;
    wb_data_o = '0;
    f_stall_o = 1'b1;
    f_ack_o   = 1'b0;
    f_err_o   = 1'b0;
    f_data_o  = '0;
    m_stall_o = 1'b1;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_data_o  = '0;
    unique case (state)
      GNT_F: begin
        wb_cyc_o  = f_cyc_i;
        wb_stb_o  = f_cyc_i & f_stb_i;
        wb_addr_o = f_addr_i;
        f_stall_o = wb_stall_i;
        f_ack_o   = wb_ack_i & f_cyc_i;
        f_data_o  = wb_data_i;
      end
      GNT_M: begin
        wb_cyc_o  = m_cyc_i;
        wb_stb_o  = m_cyc_i & m_stb_i;
        wb_we_o   = m_cyc_i & m_we_i;
        wb_addr_o = m_addr_i;
        wb_data_o = m_data_i;
        m_stall_o = wb_stall_i;
        m_ack_o   = wb_ack_i & m_cyc_i;
        m_data_o  = wb_data_i;
      end
      ABORT: begin
        f_err_o = !own_m;
        m_err_o = own_m;
      end
      default: begin
      end
    endcase
  end

endmodule
